// File: rtl/mux2_arbiter_pkg.sv
// Shared types for the two-requester bus-mux arbiter.
package mux2_arb_pkg;

   typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} arb_state_t;

   typedef logic arb_src_t;

   // Requester 1 is "last" after reset so requester 0 wins the first contention
   localparam arb_src_t SRC_RESET_LAST = 1'b1;

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// Plain 2:1 data mux: y = a when s==0, b when s==1.
module mux2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin/burst arbiter feeding a one-entry output register.
// Define ARB_FIXED_PRI_EN to make requester 0 always win contention.
module mux2_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BURST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   localparam int CW = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   arb_state_t       state;
   arb_src_t         last;
   logic [CW-1:0]    cnt;
   arb_src_t         winner;
   logic             has_win;
   logic             accept;
   logic [WIDTH-1:0] mux_y;

   assign out_valid = (state != IDLE);
   assign out_src   = (state == HOLD1);

   always_comb begin
      has_win = req0_valid | req1_valid;
      accept  = (!out_valid | out_ready) & !reset;
      winner  = 1'b0;
`ifdef ARB_FIXED_PRI_EN
      winner = req0_valid ? 1'b0 : 1'b1;
`else
      if (req0_valid && req1_valid)
         winner = (cnt < BURST_C) ? last : ~last;
      else
         winner = req0_valid ? 1'b0 : 1'b1;
`endif
      req0_ready = accept & req0_valid & (winner == 1'b0);
      req1_ready = accept & req1_valid & (winner == 1'b1);
   end

   mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .a (req0_data),
      .b (req1_data),
      .s (winner),
      .y (mux_y)
   );

   // Output register stage: captures the steered word when the slot is free or draining
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         out_data <= '0;
         last     <= SRC_RESET_LAST;
         cnt      <= BURST_C;
      end else if (accept) begin
         if (has_win) begin
            out_data <= mux_y;
            state    <= winner ? HOLD1 : HOLD0;
            if (winner == last) begin
               cnt <= (cnt == BURST_C) ? cnt : cnt + CW'(1);
            end else begin
               last <= winner;
               cnt  <= CW'(1);
            end
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench: two arbiters (BURST=1 and BURST=3) share one stimulus stream.
module tb_mux2_arbiter;

`ifdef ARB_FIXED_PRI_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       v0, v1, ordy;
   logic [7:0] d0, d1;

   logic       r0_a, r1_a, ov_a, os_a;
   logic [7:0] od_a;
   logic       r0_b, r1_b, ov_b, os_b;
   logic [7:0] od_b;

   logic [8:0] q_a[$];
   logic [8:0] q_b[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux2_arbiter #(.WIDTH(8), .BURST(1)) dut_a (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_data(d0), .req0_ready(r0_a),
      .req1_valid(v1), .req1_data(d1), .req1_ready(r1_a),
      .out_valid(ov_a), .out_data(od_a), .out_src(os_a), .out_ready(ordy)
   );

   mux2_arbiter #(.WIDTH(8), .BURST(3)) dut_b (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req0_data(d0), .req0_ready(r0_b),
      .req1_valid(v1), .req1_data(d1), .req1_ready(r1_b),
      .out_valid(ov_b), .out_data(od_b), .out_src(os_b), .out_ready(ordy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: a word is consumed when valid & ready are seen away from the edge
   always @(negedge clk) begin
      if (ov_a === 1'b1 && ordy === 1'b1) begin
         if (q_a.size() == 0) chk("b1_unexpected_word", {os_a, od_a}, 9'h1ff);
         else chk("b1_word", {os_a, od_a}, q_a.pop_front());
      end
      if (ov_b === 1'b1 && ordy === 1'b1) begin
         if (q_b.size() == 0) chk("b3_unexpected_word", {os_b, od_b}, 9'h1ff);
         else chk("b3_word", {os_b, od_b}, q_b.pop_front());
      end
   end

   task automatic drive(input logic rst, input logic iv0, input logic [7:0] id0,
                        input logic iv1, input logic [7:0] id1, input logic ir);
      @(posedge clk);
      #1;
      reset = rst; v0 = iv0; d0 = id0; v1 = iv1; d1 = id1; ordy = ir;
      @(negedge clk);
   endtask

   task automatic chk_rdy(input string nm, input logic e0a, input logic e1a,
                          input logic e0b, input logic e1b);
      chk({nm, "_b1_rdy"}, {r0_a, r1_a}, {e0a, e1a});
      chk({nm, "_b3_rdy"}, {r0_b, r1_b}, {e0b, e1b});
   endtask

   initial begin
      logic [7:0] rr_data_a[7];
      logic [7:0] rr_data_b[7];
      logic       src_a, src_b;

      reset = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 8'h00; d1 = 8'h00; ordy = 1'b1;

      // Reset held 2 cycles with both requesters valid
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
         chk("rst_ov_a", ov_a, 1'b0);
         chk("rst_os_a", os_a, 1'b0);
         chk("rst_ov_b", ov_b, 1'b0);
         chk("rst_od_b", od_b, 8'h00);
         chk_rdy("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Single source
      drive(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      chk_rdy("single", 1'b1, 1'b0, 1'b1, 1'b0);
      q_a.push_back({1'b0, 8'hA5});
      q_b.push_back({1'b0, 8'hA5});
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("single_ov_a", ov_a, 1'b1);
      chk("single_os_a", os_a, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("idle_ov_a", ov_a, 1'b0);

      // Restart arbitration state, then continuous contention for 7 cycles
      drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 7; i++) begin
         src_a = FIXED ? 1'b0 : ((i % 2) == 1);
         src_b = FIXED ? 1'b0 : (i >= 3 && i <= 5);
         drive(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
         chk_rdy($sformatf("contend%0d", i), !src_a, src_a, !src_b, src_b);
         rr_data_a[i] = src_a ? 8'h22 : 8'h11;
         rr_data_b[i] = src_b ? 8'h22 : 8'h11;
         q_a.push_back({src_a, rr_data_a[i]});
         q_b.push_back({src_b, rr_data_b[i]});
      end

      // Backpressure: load 33, stall 3 cycles with both requesters waiting
      drive(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
      chk_rdy("bp_load", 1'b1, 1'b0, 1'b1, 1'b0);
      q_a.push_back({1'b0, 8'h33});
      q_b.push_back({1'b0, 8'h33});
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'h44, 1'b1, 8'h55, 1'b0);
         chk_rdy($sformatf("bp_stall%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
         chk("bp_hold_a", {ov_a, os_a, od_a}, {1'b1, 1'b0, 8'h33});
         chk("bp_hold_b", {ov_b, os_b, od_b}, {1'b1, 1'b0, 8'h33});
      end
      // Release: held word drains and the next one loads in the same cycle
      drive(1'b0, 1'b1, 8'h44, 1'b1, 8'h55, 1'b1);
      src_a = FIXED ? 1'b0 : 1'b1;
      chk_rdy("bp_release", !src_a, src_a, 1'b1, 1'b0);
      q_a.push_back(src_a ? {1'b1, 8'h55} : {1'b0, 8'h44});
      q_b.push_back({1'b0, 8'h44});
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("drain_ov_a", ov_a, 1'b0);

      // Reset while holding a word from requester 1
      drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h66, 1'b1);
      chk_rdy("hold1_load", 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
      chk("hold1_a", {ov_a, os_a, od_a}, {1'b1, 1'b1, 8'h66});
      chk_rdy("hold1_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("midrst_ov_a", ov_a, 1'b0);
      chk("midrst_ov_b", ov_b, 1'b0);
      chk("midrst_od_b", od_b, 8'h00);

      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("q_a_empty", q_a.size(), 0);
      chk("q_b_empty", q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
